// File: rtl/design_select_sequencer.sv
// design_select_sequencer
//   Owns the design_select bus that feeds the integration mux. A new
//   selection is taken over a valid/ready handshake. The mux is then parked
//   at code 0 (no design, every GPIO an input, every design in reset) for
//   GUARD_CYCLES cycles before the new code is committed. This enforces
//   break-before-make between designs. Codes above NUM_DESIGNS are turned
//   into 0 and flagged.
//
// Ports
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   req_select     requested design code
//   req_valid      request valid; the requester holds it until it is accepted
//   req_ready      high while a request can be accepted (IDLE)
//   design_select  registered select driven to the integration mux
//   switch_busy    high while parked at 0 (switch in progress)
//   switch_done    one-cycle pulse: request finished, design_select is final
//   req_error      one-cycle pulse: the accepted code was out of range
module design_select_sequencer #(
  parameter int NUM_DESIGNS  = 12,
  parameter int SEL_W        = 4,
  parameter int GUARD_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [SEL_W-1:0] req_select,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [SEL_W-1:0] design_select,
  output logic             switch_busy,
  output logic             switch_done,
  output logic             req_error
);

  typedef enum logic {
    IDLE = 1'b0,
    PARK = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SEL_W-1:0]   pending_reg, pending_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic               accept;
  logic               in_range;
  logic [SEL_W-1:0]   eff_code;

  // Accept only in IDLE. While parked, a held request is ignored.
  assign accept   = req_valid && (state_reg == IDLE);
  assign in_range = (req_select <= SEL_W'(NUM_DESIGNS));
  assign eff_code = in_range ? req_select : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= '0;
      sel_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      sel_reg     <= sel_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    sel_next     = sel_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          pending_next = eff_code;
          err_next     = !in_range;
          if (eff_code == sel_reg) begin
            // Already selected. Finish without parking, so the bus does
            // not glitch through 0.
            done_next = 1'b1;
          end else begin
            sel_next   = '0;
            cnt_next   = CNT_W'(GUARD_CYCLES - 1);
            state_next = PARK;
          end
        end
      end
      PARK: begin
        // The counter is loaded with GUARD_CYCLES-1 and is tested for 0
        // before it is decremented. That gives exactly GUARD_CYCLES cycles
        // at 0 before the commit.
        if (cnt_reg == '0) begin
          sel_next   = pending_reg;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every output is decoded from a flop. No input reaches an output
  // combinationally.
  assign req_ready     = (state_reg == IDLE);
  assign switch_busy   = (state_reg == PARK);
  assign design_select = sel_reg;
  assign switch_done   = done_reg;
  assign req_error     = err_reg;

endmodule

// File: tb/tb_design_select_sequencer.sv
module tb_design_select_sequencer;

  localparam int NUM_DESIGNS  = 12;
  localparam int SEL_W        = 4;
  localparam int GUARD_CYCLES = 16;
  localparam int CNT_W        = 8;

  logic             clk;
  logic             n_rst;
  logic [SEL_W-1:0] req_select;
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] design_select;
  logic             switch_busy;
  logic             switch_done;
  logic             req_error;

  int checks = 0;
  int errors = 0;

  // Scoreboard of final select values, one entry per request.
  logic [SEL_W-1:0] exp_q[$];
  logic [SEL_W-1:0] prev_sel;

  design_select_sequencer #(
    .NUM_DESIGNS (NUM_DESIGNS),
    .SEL_W       (SEL_W),
    .GUARD_CYCLES(GUARD_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req_select   (req_select),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .design_select(design_select),
    .switch_busy  (switch_busy),
    .switch_done  (switch_done),
    .req_error    (req_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every switch_done pulse.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && switch_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(switch_done), 32'(0));
      end else begin
        chk("sb_final_select", 32'(design_select), 32'(exp_q.pop_front()));
      end
    end
  end

  // Break-before-make: design_select never moves directly between two
  // different nonzero codes.
  always @(negedge clk) begin
    if (prev_sel !== 'x && prev_sel != '0 && design_select != '0 && design_select != prev_sel)
      chk("break_before_make", 32'(design_select), 32'(0));
    prev_sel <= design_select;
  end

  // Drives one request, follows it to its switch_done pulse and checks the
  // park length, the busy/ready/select values while parked, and the error
  // pulse timing. Entered and left on a negedge.
  task automatic run_req(input logic [SEL_W-1:0] code, input int exp_park, input string tag);
    logic [SEL_W-1:0] eff;
    logic             exp_err;
    int               c;
    bit               done_seen;
    exp_err = (code > SEL_W'(NUM_DESIGNS));
    eff     = exp_err ? '0 : code;
    chk({tag, "_ready_before"}, 32'(req_ready), 32'(1));
    req_select = code;
    req_valid  = 1'b1;
    exp_q.push_back(eff);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_select = SEL_W'($urandom_range(1, 15)); // must not affect the pending code
    done_seen  = 1'b0;
    for (c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, "_error_pulse"}, 32'(req_error), 32'(exp_err));
      else        chk({tag, "_error_quiet"}, 32'(req_error), 32'(0));
      if (switch_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      chk({tag, "_busy"}, 32'(switch_busy), 32'(1));
      chk({tag, "_ready_low"}, 32'(req_ready), 32'(0));
      chk({tag, "_parked_zero"}, 32'(design_select), 32'(0));
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'(1));
    chk({tag, "_done_cycle"}, 32'(c), 32'(exp_park + 1));
    chk({tag, "_busy_end"}, 32'(switch_busy), 32'(0));
    chk({tag, "_ready_end"}, 32'(req_ready), 32'(1));
    chk({tag, "_select_end"}, 32'(design_select), 32'(eff));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(switch_done), 32'(0));
  endtask

  initial begin
    n_rst      = 1'b0;
    req_valid  = 1'b0;
    req_select = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_select", 32'(design_select), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(switch_busy), 32'(0));
    chk("rst_done", 32'(switch_done), 32'(0));
    chk("rst_error", 32'(req_error), 32'(0));
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'(1));

    // 2..5 plus boundary codes
    run_req(4'd5, GUARD_CYCLES, "sel_0_to_5");
    run_req(4'd9, GUARD_CYCLES, "sel_5_to_9");
    run_req(4'd14, GUARD_CYCLES, "sel_9_to_14_err");
    run_req(4'd13, 0, "sel_0_to_13_err_nop");
    run_req(4'd9, GUARD_CYCLES, "sel_0_to_9");
    run_req(4'd9, 0, "sel_9_to_9_nop");
    run_req(4'd12, GUARD_CYCLES, "sel_9_to_12_max");
    run_req(4'd3, GUARD_CYCLES, "sel_12_to_3");

    // 6: reset in the middle of a park
    req_select = 4'd7;
    req_valid  = 1'b1;
    exp_q.push_back(4'd7);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_parked_zero", 32'(design_select), 32'(0));
    chk("abort_busy", 32'(switch_busy), 32'(1));
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_async_select", 32'(design_select), 32'(0));
    chk("abort_async_busy", 32'(switch_busy), 32'(0));
    chk("abort_async_ready", 32'(req_ready), 32'(1));
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(switch_done), 32'(0));
      chk("abort_no_error", 32'(req_error), 32'(0));
    end
    n_rst = 1'b1;
    @(negedge clk);
    chk("abort_after_select", 32'(design_select), 32'(0));
    chk("abort_after_done", 32'(switch_done), 32'(0));
    run_req(4'd7, GUARD_CYCLES, "sel_0_to_7_retry");

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
